// File: rtl/simple_proc_param.sv
// Parametrised multicycle processor: 2**REG_SEL_W registers, accumulator A, ALU result G, zero flag Z.
// Optional conditional move (opcode 110) enabled by defining PROC_MVNZ_EN; otherwise 110 is a NOP.
module simple_proc_param #(
    parameter int DATA_W    = 16,
    parameter int REG_SEL_W = 3,
    localparam int IR_W     = 3 + 2*REG_SEL_W,
    localparam int NREGS    = 2**REG_SEL_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic              done,
    output logic [DATA_W-1:0] bus_out,
    output logic [IR_W-1:0]   ir_out,
    output logic [1:0]        step_out
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    step_t              r_step;
    logic [IR_W-1:0]    r_ir;
    logic [DATA_W-1:0]  r_regs [NREGS];
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_g;
    logic               r_z;

    step_t                w_step_nxt;
    logic [DATA_W-1:0]    w_bus;
    logic                 w_done;
    logic                 w_ir_ld;
    logic                 w_rx_wr;
    logic                 w_a_ld;
    logic                 w_g_ld;
    logic [DATA_W-1:0]    w_alu;
    logic [2:0]           w_op;
    logic [REG_SEL_W-1:0] w_rx;
    logic [REG_SEL_W-1:0] w_ry;

    assign w_op = r_ir[IR_W-1 -: 3];
    assign w_rx = r_ir[2*REG_SEL_W-1 -: REG_SEL_W];
    assign w_ry = r_ir[REG_SEL_W-1:0];

    // Step sequencing and the single bus source for each step
    always_comb begin
        w_step_nxt = r_step;
        w_bus      = '0;
        w_done     = 1'b0;
        w_ir_ld    = 1'b0;
        w_rx_wr    = 1'b0;
        w_a_ld     = 1'b0;
        w_g_ld     = 1'b0;
        case (r_step)
            T0: begin
                if (run) begin
                    w_ir_ld    = 1'b1;
                    w_step_nxt = T1;
                end
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_bus      = r_regs[w_ry];
                        w_rx_wr    = 1'b1;
                        w_done     = 1'b1;
                        w_step_nxt = T0;
                    end
                    OP_MVI: begin
                        w_bus      = din;
                        w_rx_wr    = 1'b1;
                        w_done     = 1'b1;
                        w_step_nxt = T0;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        w_bus      = r_regs[w_rx];
                        w_a_ld     = 1'b1;
                        w_step_nxt = T2;
                    end
`ifdef PROC_MVNZ_EN
                    OP_MVNZ: begin
                        w_bus      = r_regs[w_ry];
                        w_rx_wr    = ~r_z;
                        w_done     = 1'b1;
                        w_step_nxt = T0;
                    end
`endif
                    default: begin
                        w_done     = 1'b1;
                        w_step_nxt = T0;
                    end
                endcase
            end
            T2: begin
                w_bus      = r_regs[w_ry];
                w_g_ld     = 1'b1;
                w_step_nxt = T3;
            end
            T3: begin
                w_bus      = r_g;
                w_rx_wr    = 1'b1;
                w_done     = 1'b1;
                w_step_nxt = T0;
            end
            default: w_step_nxt = T0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_a + w_bus;
            OP_SUB:  w_alu = r_a - w_bus;
            OP_AND:  w_alu = r_a & w_bus;
            OP_OR:   w_alu = r_a | w_bus;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_step <= T0;
            r_ir   <= '0;
            r_a    <= '0;
            r_g    <= '0;
            r_z    <= 1'b1;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_step <= w_step_nxt;
            if (w_ir_ld) r_ir <= din[DATA_W-1 -: IR_W];
            if (w_a_ld)  r_a  <= w_bus;
            if (w_g_ld) begin
                r_g <= w_alu;
                r_z <= (w_alu == '0);
            end
            if (w_rx_wr) r_regs[w_rx] <= w_bus;
        end
    end

    assign done     = w_done;
    assign bus_out  = w_bus;
    assign ir_out   = r_ir;
    assign step_out = r_step;

endmodule
